// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-master RAM arbiter.
// Master ids and the RAM read latency the return path is built around.
package ram_arb_pkg;

    typedef logic master_id_t;

    localparam master_id_t M0 = 1'b0;
    localparam master_id_t M1 = 1'b1;

    // Cycles from RAM sampling a read to data_out being valid.
    localparam int RAM_RD_LAT = 1;

endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-way round-robin grant logic with single-owner lock.
// Purely combinational; the owning block holds last_gnt and lock state.
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  master_id_t last_gnt,
    input  logic       lock,
    input  master_id_t lock_id,
    output logic [1:0] gnt
);

    // A locked owner is the only candidate; otherwise a tie goes away from last_gnt.
    always_comb begin
        gnt = 2'b00;
        if (lock) begin
            gnt[lock_id] = req[lock_id];
        end else if (req == 2'b11) begin
            gnt[~last_gnt] = 1'b1;
        end else begin
            gnt = req;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Two-master arbiter in front of a single-port synchronous RAM.
// Round-robin with an optional one-cycle lock; read data steered back by id.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int A = 10,
    parameter int D = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         m0_req,
    input  logic         m0_write,
    input  logic         m0_lock,
    input  logic [A-1:0] m0_addr,
    input  logic [D-1:0] m0_wdata,
    input  logic         m1_req,
    input  logic         m1_write,
    input  logic         m1_lock,
    input  logic [A-1:0] m1_addr,
    input  logic [D-1:0] m1_wdata,
    output logic         m0_gnt,
    output logic         m1_gnt,
    output logic         m0_rvalid,
    output logic         m1_rvalid,
    output logic [D-1:0] m0_rdata,
    output logic [D-1:0] m1_rdata,
    output logic         ram_cs,
    output logic         ram_write,
    output logic [A-1:0] ram_addr,
    output logic [D-1:0] ram_wdata,
    input  logic [D-1:0] ram_rdata
);

    master_id_t last_gnt;
    logic       owner_lock;
    master_id_t lock_id;

    // Read-return pipeline, one stage per cycle of RAM latency.
    logic       [RAM_RD_LAT-1:0] rd_pend;
    master_id_t [RAM_RD_LAT-1:0] rd_id;

    logic [1:0]   req;
    logic [1:0]   gnt_arb;
    logic [1:0]   gnt;
    logic         any_gnt;
    master_id_t   win_id;
    logic         win_write;
    logic         win_lock;
    logic [A-1:0] win_addr;
    logic [D-1:0] win_wdata;

    assign req = {m1_req, m0_req};

    rr_arb2 u_arb (
        .req      (req),
        .last_gnt (last_gnt),
        .lock     (owner_lock),
        .lock_id  (lock_id),
        .gnt      (gnt_arb)
    );

    // Nothing is accepted while reset is held.
    assign gnt     = reset ? 2'b00 : gnt_arb;
    assign any_gnt = |gnt;
    assign m0_gnt  = gnt[0];
    assign m1_gnt  = gnt[1];

    // Route the winner's request onto the RAM port; idle port is all zero.
    always_comb begin
        win_id    = M0;
        win_write = 1'b0;
        win_lock  = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        unique case (1'b1)
            gnt[0]: begin
                win_id    = M0;
                win_write = m0_write;
                win_lock  = m0_lock;
                win_addr  = m0_addr;
                win_wdata = m0_wdata;
            end
            gnt[1]: begin
                win_id    = M1;
                win_write = m1_write;
                win_lock  = m1_lock;
                win_addr  = m1_addr;
                win_wdata = m1_wdata;
            end
            default: ;
        endcase
    end

    assign ram_cs    = any_gnt;
    assign ram_write = win_write;
    assign ram_addr  = win_addr;
    assign ram_wdata = win_wdata;

    // Fairness and lock state; an idle owner drops the lock after one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_gnt   <= M1;
            owner_lock <= 1'b0;
            lock_id    <= M0;
        end else if (any_gnt) begin
            last_gnt   <= win_id;
            owner_lock <= win_lock;
            lock_id    <= win_id;
        end else if (owner_lock && !req[lock_id]) begin
            owner_lock <= 1'b0;
        end
    end

    // Track granted reads so the RAM output can be tagged with its master.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pend <= '0;
            rd_id   <= '0;
        end else begin
            rd_pend[0] <= any_gnt && !win_write;
            rd_id[0]   <= win_id;
            for (int i = 1; i < RAM_RD_LAT; i++) begin
                rd_pend[i] <= rd_pend[i-1];
                rd_id[i]   <= rd_id[i-1];
            end
        end
    end

    assign m0_rvalid = rd_pend[RAM_RD_LAT-1] && (rd_id[RAM_RD_LAT-1] == M0);
    assign m1_rvalid = rd_pend[RAM_RD_LAT-1] && (rd_id[RAM_RD_LAT-1] == M1);

    // RAM output passes straight through, held at zero for the non-owner.
    assign m0_rdata = m0_rvalid ? ram_rdata : '0;
    assign m1_rdata = m1_rvalid ? ram_rdata : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 1-cycle RAM behind it.
// Inputs change 1ns after posedge; outputs are sampled at negedge.
module tb_ram_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       m0_req, m0_write, m0_lock;
    logic [9:0] m0_addr;
    logic [7:0] m0_wdata;
    logic       m1_req, m1_write, m1_lock;
    logic [9:0] m1_addr;
    logic [7:0] m1_wdata;
    logic       m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [7:0] m0_rdata, m1_rdata;
    logic       ram_cs, ram_write;
    logic [9:0] ram_addr;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata = 8'h00;

    logic [7:0] mem [0:1023];

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.A(10), .D(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .m0_req    (m0_req),
        .m0_write  (m0_write),
        .m0_lock   (m0_lock),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m1_req    (m1_req),
        .m1_write  (m1_write),
        .m1_lock   (m1_lock),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m0_gnt    (m0_gnt),
        .m1_gnt    (m1_gnt),
        .m0_rvalid (m0_rvalid),
        .m1_rvalid (m1_rvalid),
        .m0_rdata  (m0_rdata),
        .m1_rdata  (m1_rdata),
        .ram_cs    (ram_cs),
        .ram_write (ram_write),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    // Single-port RAM: data_out only updates on reads.
    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_write) mem[ram_addr] <= ram_wdata;
            else           ram_rdata     <= mem[ram_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drv0(input logic r, input logic w, input logic l,
                        input logic [9:0] a, input logic [7:0] d);
        m0_req = r; m0_write = w; m0_lock = l; m0_addr = a; m0_wdata = d;
    endtask

    task automatic drv1(input logic r, input logic w, input logic l,
                        input logic [9:0] a, input logic [7:0] d);
        m1_req = r; m1_write = w; m1_lock = l; m1_addr = a; m1_wdata = d;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        mem[10'h001] = 8'h11;
        mem[10'h002] = 8'h22;
        mem[10'h020] = 8'h44;
        mem[10'h030] = 8'h33;

        reset = 1'b1;
        drv0(1'b1, 1'b0, 1'b0, 10'h001, 8'h00);
        drv1(1'b1, 1'b0, 1'b0, 10'h002, 8'h00);

        // Reset: no grants, no RAM access, no responses
        @(negedge clk);
        @(negedge clk);
        chk("rst_m0_gnt", m0_gnt, 0);
        chk("rst_m1_gnt", m1_gnt, 0);
        chk("rst_ram_cs", ram_cs, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_rvalid", {m0_rvalid, m1_rvalid}, 0);
        chk("rst_rdata", {m0_rdata, m1_rdata}, 0);

        // M0 write 0x5A to 0x010
        next_cycle();
        reset = 1'b0;
        drv0(1'b1, 1'b1, 1'b0, 10'h010, 8'h5A);
        drv1(1'b0, 1'b0, 1'b0, 10'h000, 8'h00);
        @(negedge clk);
        chk("t1_wr_gnt", m0_gnt, 1);
        chk("t1_wr_port", {ram_cs, ram_write, ram_addr, ram_wdata}, {1'b1, 1'b1, 10'h010, 8'h5A});
        chk("t1_m1_gnt", m1_gnt, 0);

        // M0 read 0x010
        next_cycle();
        drv0(1'b1, 1'b0, 1'b0, 10'h010, 8'h00);
        @(negedge clk);
        chk("t1_rd_gnt", m0_gnt, 1);
        chk("t1_wr_noresp", m0_rvalid, 0);
        chk("t1_rd_port", {ram_cs, ram_write, ram_addr}, {1'b1, 1'b0, 10'h010});

        // Read returns; M1 write makes M1 the last winner
        next_cycle();
        drv0(1'b0, 1'b0, 1'b0, 10'h000, 8'h00);
        drv1(1'b1, 1'b1, 1'b0, 10'h100, 8'h99);
        @(negedge clk);
        chk("t1_rvalid", m0_rvalid, 1);
        chk("t1_rdata", m0_rdata, 8'h5A);
        chk("t1_m1_quiet", {m1_rvalid, m1_rdata}, 0);
        chk("t1_m1_wr_gnt", m1_gnt, 1);

        // Both masters read continuously: M0, M1, M0, M1
        next_cycle();
        drv0(1'b1, 1'b0, 1'b0, 10'h001, 8'h00);
        drv1(1'b1, 1'b0, 1'b0, 10'h002, 8'h00);
        @(negedge clk);
        chk("t2_c0_gnt", {m1_gnt, m0_gnt}, 2'b01);
        chk("t2_c0_rvalid", {m1_rvalid, m0_rvalid}, 2'b00);
        next_cycle();
        @(negedge clk);
        chk("t2_c1_gnt", {m1_gnt, m0_gnt}, 2'b10);
        chk("t2_c1_rvalid", {m1_rvalid, m0_rvalid}, 2'b01);
        chk("t2_c1_rdata", m0_rdata, 8'h11);
        next_cycle();
        @(negedge clk);
        chk("t2_c2_gnt", {m1_gnt, m0_gnt}, 2'b01);
        chk("t2_c2_rvalid", {m1_rvalid, m0_rvalid}, 2'b10);
        chk("t2_c2_rdata", m1_rdata, 8'h22);
        next_cycle();
        @(negedge clk);
        chk("t2_c3_gnt", {m1_gnt, m0_gnt}, 2'b10);
        chk("t2_c3_rvalid", {m1_rvalid, m0_rvalid}, 2'b01);
        chk("t2_c3_rdata", m0_rdata, 8'h11);

        // M0 alone so that M0 becomes last winner before the lock test
        next_cycle();
        drv0(1'b1, 1'b0, 1'b0, 10'h020, 8'h00);
        drv1(1'b0, 1'b0, 1'b0, 10'h000, 8'h00);
        @(negedge clk);
        chk("t2_c4_rvalid", {m1_rvalid, m0_rvalid}, 2'b10);
        chk("t2_c4_rdata", m1_rdata, 8'h22);
        chk("t3_pre_gnt", m0_gnt, 1);

        // M1 locked read of 0x020 wins the tie (last was M0)
        next_cycle();
        drv1(1'b1, 1'b0, 1'b1, 10'h020, 8'h00);
        @(negedge clk);
        chk("t3_lrd_gnt", {m1_gnt, m0_gnt}, 2'b10);

        // M1 write under lock: M0 blocked though it would win the tie
        next_cycle();
        drv1(1'b1, 1'b1, 1'b0, 10'h020, 8'h21);
        @(negedge clk);
        chk("t3_lwr_gnt", {m1_gnt, m0_gnt}, 2'b10);
        chk("t3_lrd_rvalid", m1_rvalid, 1);
        chk("t3_lrd_rdata", m1_rdata, 8'h44);

        // Lock released: M0 finally granted
        next_cycle();
        drv1(1'b0, 1'b0, 1'b0, 10'h000, 8'h00);
        @(negedge clk);
        chk("t3_m0_gnt", {m1_gnt, m0_gnt}, 2'b01);
        chk("t3_wr_noresp", {m1_rvalid, m0_rvalid}, 2'b00);

        // M0 sees 0x21; M1 starts a locked read with no follow-up
        next_cycle();
        drv0(1'b0, 1'b0, 1'b0, 10'h000, 8'h00);
        drv1(1'b1, 1'b0, 1'b1, 10'h002, 8'h00);
        @(negedge clk);
        chk("t3_final_rvalid", m0_rvalid, 1);
        chk("t3_final_rdata", m0_rdata, 8'h21);
        chk("t4_lrd_gnt", m1_gnt, 1);

        // Owner idle: M0 blocked for exactly this cycle
        next_cycle();
        drv1(1'b0, 1'b0, 1'b0, 10'h000, 8'h00);
        drv0(1'b1, 1'b0, 1'b0, 10'h001, 8'h00);
        @(negedge clk);
        chk("t4_blocked", {m1_gnt, m0_gnt, ram_cs}, 3'b000);
        chk("t4_rvalid", m1_rvalid, 1);
        chk("t4_rdata", m1_rdata, 8'h22);
        next_cycle();
        @(negedge clk);
        chk("t4_released", {m1_gnt, m0_gnt}, 2'b01);

        // M0 read of 0x002 whose return is killed by reset
        next_cycle();
        drv0(1'b1, 1'b0, 1'b0, 10'h002, 8'h00);
        @(negedge clk);
        chk("t5_prev_rdata", {m0_rvalid, m0_rdata}, {1'b1, 8'h11});
        chk("t5_rd_gnt", m0_gnt, 1);
        next_cycle();
        drv0(1'b0, 1'b0, 1'b0, 10'h000, 8'h00);
        reset = 1'b1;
        #1;
        chk("t5_async_kill", {m0_rvalid, m1_rvalid}, 2'b00);
        @(negedge clk);
        chk("t5_rst_rvalid", m0_rvalid, 0);

        // After reset the first contention goes to M0
        next_cycle();
        reset = 1'b0;
        drv0(1'b1, 1'b0, 1'b0, 10'h001, 8'h00);
        drv1(1'b1, 1'b0, 1'b0, 10'h002, 8'h00);
        @(negedge clk);
        chk("t5_no_replay", {m1_rvalid, m0_rvalid}, 2'b00);
        chk("t5_first_gnt", {m1_gnt, m0_gnt}, 2'b01);

        next_cycle();
        drv0(1'b0, 1'b0, 1'b0, 10'h000, 8'h00);
        @(negedge clk);
        chk("t5_m1_gnt", m1_gnt, 1);
        chk("t5_rdata", {m0_rvalid, m0_rdata}, {1'b1, 8'h11});

        // Pipelined mix on 0x030: read, write 0x77, read
        next_cycle();
        drv1(1'b0, 1'b0, 1'b0, 10'h000, 8'h00);
        drv0(1'b1, 1'b0, 1'b0, 10'h030, 8'h00);
        @(negedge clk);
        chk("t6_n_gnt", m0_gnt, 1);
        chk("t6_n_m1ret", {m1_rvalid, m1_rdata}, {1'b1, 8'h22});
        next_cycle();
        drv0(1'b0, 1'b0, 1'b0, 10'h000, 8'h00);
        drv1(1'b1, 1'b1, 1'b0, 10'h030, 8'h77);
        @(negedge clk);
        chk("t6_n1_gnt", m1_gnt, 1);
        chk("t6_n1_old", {m0_rvalid, m0_rdata}, {1'b1, 8'h33});
        next_cycle();
        drv1(1'b0, 1'b0, 1'b0, 10'h000, 8'h00);
        drv0(1'b1, 1'b0, 1'b0, 10'h030, 8'h00);
        @(negedge clk);
        chk("t6_n2_gnt", m0_gnt, 1);
        chk("t6_n2_noresp", {m1_rvalid, m0_rvalid}, 2'b00);
        next_cycle();
        drv0(1'b0, 1'b0, 1'b0, 10'h000, 8'h00);
        @(negedge clk);
        chk("t6_n3_new", {m0_rvalid, m0_rdata}, {1'b1, 8'h77});
        chk("t6_idle_port", {ram_cs, ram_write, ram_addr, ram_wdata}, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-master arbiter in front of the single-port synchronous `ram` block (1-cycle read latency, read/write selected by `cs`/`write`). It multiplexes a CPU-side port (M0) and a loader/DMA-side port (M1) onto the RAM port with round-robin fairness and an optional lock for read-modify-write sequences. It returns read data to the issuing master with a valid strobe. It sits directly upstream of `ram`, between the bus masters and the memory.

## Interface
Parameters:
- `A`, 10, address width (matches RAM)
- `D`, 8, data width (matches RAM)

Ports:
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `m0_req` / `m1_req`  in  1  request; held with its qualifiers until granted
- `m0_write` / `m1_write`  in  1  1 = write, 0 = read
- `m0_lock` / `m1_lock`  in  1  keep ownership for the next cycle after this grant
- `m0_addr` / `m1_addr`  in  A  word address
- `m0_wdata` / `m1_wdata`  in  D  write data
- `m0_gnt` / `m1_gnt`  out  1  request accepted this cycle (combinational)
- `m0_rvalid` / `m1_rvalid`  out  1  read data valid this cycle
- `m0_rdata` / `m1_rdata`  out  D  read data; meaningful only with rvalid
- `ram_cs`, `ram_write`  out  1  to RAM
- `ram_addr`  out  A  to RAM
- `ram_wdata`  out  D  to RAM `data_in`
- `ram_rdata`  in  D  from RAM `data_out`

## Operation
- State: `last_gnt` (1 bit, id of the most recently granted master), `owner_lock` (1 bit, lock active) with `lock_id` (1 bit), `rd_pend` (1 bit) with `rd_id` (1 bit).
- Grant decision each cycle:
  - If `owner_lock` is set, only `lock_id` may be granted. The other master waits even if the owner is not requesting.
  - Otherwise, if exactly one master requests, grant it.
  - If both request, grant the master other than `last_gnt`.
- The winner's write/addr/wdata drive the RAM port with `ram_cs`=1. With no grant, `ram_cs`=0, and `ram_addr`, `ram_wdata` and `ram_write` are 0.
- On a grant, `last_gnt` takes the winner id. `owner_lock` takes the winner's lock bit, with `lock_id` set to the winner.
- A cycle with `owner_lock` set and no request from the owner clears `owner_lock`, so a lock lasts at most one idle cycle.
- On a granted read, `rd_pend`=1 and `rd_id`=winner at the next edge; otherwise `rd_pend`=0.
- `mX_rvalid` = `rd_pend` && `rd_id`==X. Both `rdata` outputs are driven from `ram_rdata` unregistered.
- Writes produce no response; `gnt` is the completion.
- Reset values:
  - all outputs 0
  - `last_gnt`=1, so M0 wins the first contention
  - `owner_lock`=0, `rd_pend`=0

## Timing
- Grant: same cycle as request (combinational). Back-to-back grants are allowed every cycle.
- Read: granted in cycle N, RAM samples at the end of N, `rvalid`+`rdata` are valid in cycle N+1. Fixed latency of 1, throughput of 1 per cycle.
- Write: granted in cycle N, committed to RAM at the end of N. A read of the same address granted in N+1 returns the new data in N+2.
- Simultaneous events:
  - A read grant in cycle N+1 while cycle N's read returns is legal. Return and issue overlap.
  - A write granted in N+1 while N's read returns still delivers N's data (RAM holds `data_out` on writes).
- Reset asserted mid-read: `rvalid` is forced to 0 immediately (async). The in-flight read is discarded, not replayed.
- A master dropping `req` before `gnt` is a protocol violation; the behaviour is unspecified but must not hang the arbiter.

## Structure
- Package `ram_arb_pkg` holds `typedef logic master_id_t` and constants `M0`=0, `M1`=1. The RAM timing constant `RAM_RD_LAT`=1 also lives there. The datapath assumes this latency.
- One sub-module, `rr_arb2`:
  - inputs: `req[1:0]`, `last_gnt`, `lock`, `lock_id`
  - output: one-hot `gnt[1:0]`
  - purely combinational
- `ram_arbiter` holds the state registers and the port muxing, and instantiates `rr_arb2`.

## Test plan
- Reset, then M0 writes 0x5A to addr 0x010 and M0 reads 0x010 → `m0_gnt` is 1 in both cycles; `m0_rvalid`=1 with `m0_rdata`=0x5A exactly one cycle after the read grant; M1 outputs stay 0.
- Both masters hold read requests (M0 addr 0x001, M1 addr 0x002) for 4 cycles → grant order M0, M1, M0, M1; rvalid alternates M0, M1, M0, M1 with the matching RAM contents.
- M1 issues a locked read of 0x020 then a write of 0x21 to 0x020, while M0 requests continuously → M0 is not granted until after M1's write. The word at 0x020 ends as 0x21.
- Lock with no follow-up: M1 `lock`=1 on one read, then `m1_req`=0 → M0 is blocked for exactly one cycle, then granted.
- Reset pulse in the cycle after an M0 read grant → `m0_rvalid` is never asserted for that read. After reset, the first contention grants M0.
- Pipelined mix: M0 reads 0x030 in N, M1 writes 0x77 to 0x030 in N+1, M0 reads 0x030 in N+2 → old value returned in N+1, 0x77 returned in N+3.
